// File: rtl/idct_1d.sv
// -----------------------------------------------------------------------------
// idct_1d
//   Fully pipelined 8-point 1-D inverse DCT. It uses the 13-bit fixed-point
//   constant set shared with the forward DCT and PASS1_BITS=2 scaling.
//   One vector is accepted per clock and there is no backpressure. An input
//   vector appears on the outputs 4 edges after it is sampled.
//   horizontal=1 : first pass. Descale by 11 bits, saturate to signed 16 bits.
//   horizontal=0 : second pass. Descale by 18 bits, add 128, clamp to 0..255.
//
// Ports
//   CLK          clock, rising edge
//   RST          asynchronous active-high reset
//   i_stb        input vector valid
//   i_D0..i_D7   signed coefficients, index = frequency
//   o_stb        output vector valid, one cycle per input vector
//   o_D0..o_D7   signed samples, index = spatial position (held between strobes)
// -----------------------------------------------------------------------------
module idct_1d #(
    parameter bit horizontal = 1'b1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               i_stb,
    input  logic signed [15:0] i_D0,
    input  logic signed [15:0] i_D1,
    input  logic signed [15:0] i_D2,
    input  logic signed [15:0] i_D3,
    input  logic signed [15:0] i_D4,
    input  logic signed [15:0] i_D5,
    input  logic signed [15:0] i_D6,
    input  logic signed [15:0] i_D7,
    output logic               o_stb,
    output logic signed [15:0] o_D0,
    output logic signed [15:0] o_D1,
    output logic signed [15:0] o_D2,
    output logic signed [15:0] o_D3,
    output logic signed [15:0] o_D4,
    output logic signed [15:0] o_D5,
    output logic signed [15:0] o_D6,
    output logic signed [15:0] o_D7
);

    localparam int                 SHIFT = horizontal ? 11 : 18;
    localparam logic signed [31:0] ROUND = horizontal ? 32'sd1024 : 32'sd131072;

    function automatic logic signed [31:0] sx(input logic signed [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // Round-half-up, then an arithmetic shift that floors toward -inf.
    function automatic logic signed [15:0] descale(input logic signed [31:0] r);
        logic signed [31:0] y;
        y = (r + ROUND) >>> SHIFT;
        if (horizontal) begin
            if (y > 32'sd32767)       return 16'sh7fff;
            else if (y < -32'sd32768) return 16'sh8000;
            else                      return y[15:0];
        end else begin
            y = y + 32'sd128;
            if (y > 32'sd255)         return 16'sd255;
            else if (y < 32'sd0)      return 16'sd0;
            else                      return y[15:0];
        end
    endfunction

    logic signed [31:0] w_d [8];
    assign w_d[0] = sx(i_D0);
    assign w_d[1] = sx(i_D1);
    assign w_d[2] = sx(i_D2);
    assign w_d[3] = sx(i_D3);
    assign w_d[4] = sx(i_D4);
    assign w_d[5] = sx(i_D5);
    assign w_d[6] = sx(i_D6);
    assign w_d[7] = sx(i_D7);

    // Valid flags for stages 1..4. The data registers below have no reset
    // because only these flags decide what reaches the outputs.
    logic [3:0] r_vld;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_vld <= '0;
        else     r_vld <= {r_vld[2:0], i_stb};
    end

    // Stage 1: butterflies and odd-part sums.
    logic signed [31:0] r_s1_e0, r_s1_e1, r_s1_s26;
    logic signed [31:0] r_s1_z1, r_s1_z2, r_s1_z3, r_s1_z4, r_s1_z34;
    logic signed [31:0] r_s1_d1, r_s1_d2, r_s1_d3, r_s1_d5, r_s1_d6, r_s1_d7;

    always_ff @(posedge CLK) begin
        r_s1_e0  <= (w_d[0] + w_d[4]) <<< 13;
        r_s1_e1  <= (w_d[0] - w_d[4]) <<< 13;
        r_s1_s26 <= w_d[2] + w_d[6];
        r_s1_z1  <= w_d[7] + w_d[1];
        r_s1_z2  <= w_d[5] + w_d[3];
        r_s1_z3  <= w_d[7] + w_d[3];
        r_s1_z4  <= w_d[5] + w_d[1];
        r_s1_z34 <= (w_d[7] + w_d[3]) + (w_d[5] + w_d[1]);
        r_s1_d1  <= w_d[1];
        r_s1_d2  <= w_d[2];
        r_s1_d3  <= w_d[3];
        r_s1_d5  <= w_d[5];
        r_s1_d6  <= w_d[6];
        r_s1_d7  <= w_d[7];
    end

    // Stage 2: all constant products.
    logic signed [31:0] r_s2_m, r_s2_p6, r_s2_p2;
    logic signed [31:0] r_s2_t0, r_s2_t1, r_s2_t2, r_s2_t3;
    logic signed [31:0] r_s2_z1, r_s2_z2, r_s2_z3, r_s2_z4, r_s2_z5;
    logic signed [31:0] r_s2_e0, r_s2_e1;

    always_ff @(posedge CLK) begin
        r_s2_m  <= r_s1_s26 * 32'sd4433;
        r_s2_p6 <= r_s1_d6  * (-32'sd15137);
        r_s2_p2 <= r_s1_d2  * 32'sd6270;
        r_s2_t0 <= r_s1_d7  * 32'sd2446;
        r_s2_t1 <= r_s1_d5  * 32'sd16819;
        r_s2_t2 <= r_s1_d3  * 32'sd25172;
        r_s2_t3 <= r_s1_d1  * 32'sd12299;
        r_s2_z1 <= r_s1_z1  * (-32'sd7373);
        r_s2_z2 <= r_s1_z2  * (-32'sd20995);
        r_s2_z3 <= r_s1_z3  * (-32'sd16069);
        r_s2_z4 <= r_s1_z4  * (-32'sd3196);
        r_s2_z5 <= r_s1_z34 * 32'sd9633;
        r_s2_e0 <= r_s1_e0;
        r_s2_e1 <= r_s1_e1;
    end

    // Stage 3: even and odd partial results.
    logic signed [31:0] w_tmp2, w_tmp3, w_zz3, w_zz4;
    assign w_tmp2 = r_s2_m + r_s2_p6;
    assign w_tmp3 = r_s2_m + r_s2_p2;
    assign w_zz3  = r_s2_z3 + r_s2_z5;
    assign w_zz4  = r_s2_z4 + r_s2_z5;

    logic signed [31:0] r_s3_a10, r_s3_a11, r_s3_a12, r_s3_a13;
    logic signed [31:0] r_s3_b0, r_s3_b1, r_s3_b2, r_s3_b3;

    always_ff @(posedge CLK) begin
        r_s3_a10 <= r_s2_e0 + w_tmp3;
        r_s3_a13 <= r_s2_e0 - w_tmp3;
        r_s3_a11 <= r_s2_e1 + w_tmp2;
        r_s3_a12 <= r_s2_e1 - w_tmp2;
        r_s3_b0  <= r_s2_t0 + r_s2_z1 + w_zz3;
        r_s3_b1  <= r_s2_t1 + r_s2_z2 + w_zz4;
        r_s3_b2  <= r_s2_t2 + r_s2_z2 + w_zz3;
        r_s3_b3  <= r_s2_t3 + r_s2_z1 + w_zz4;
    end

    // Stage 4: output butterflies, indexed by spatial position.
    logic signed [31:0] r_s4_r [8];

    always_ff @(posedge CLK) begin
        r_s4_r[0] <= r_s3_a10 + r_s3_b3;
        r_s4_r[7] <= r_s3_a10 - r_s3_b3;
        r_s4_r[1] <= r_s3_a11 + r_s3_b2;
        r_s4_r[6] <= r_s3_a11 - r_s3_b2;
        r_s4_r[2] <= r_s3_a12 + r_s3_b1;
        r_s4_r[5] <= r_s3_a12 - r_s3_b1;
        r_s4_r[3] <= r_s3_a13 + r_s3_b0;
        r_s4_r[4] <= r_s3_a13 - r_s3_b0;
    end

    // The output registers load only for a valid stage-4 vector, so o_D holds
    // its last value through gaps in the input stream.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_stb <= 1'b0;
            o_D0  <= '0;
            o_D1  <= '0;
            o_D2  <= '0;
            o_D3  <= '0;
            o_D4  <= '0;
            o_D5  <= '0;
            o_D6  <= '0;
            o_D7  <= '0;
        end else begin
            o_stb <= r_vld[3];
            if (r_vld[3]) begin
                o_D0 <= descale(r_s4_r[0]);
                o_D1 <= descale(r_s4_r[1]);
                o_D2 <= descale(r_s4_r[2]);
                o_D3 <= descale(r_s4_r[3]);
                o_D4 <= descale(r_s4_r[4]);
                o_D5 <= descale(r_s4_r[5]);
                o_D6 <= descale(r_s4_r[6]);
                o_D7 <= descale(r_s4_r[7]);
            end
        end
    end

endmodule

// File: tb/tb_idct_1d.sv
// Bench for idct_1d. A pass-1 and a pass-2 instance share one stimulus
// stream. Both are compared every cycle against an integer reference model
// that is fed through a record of what was strobed in, and when.
module tb_idct_1d;

    logic               CLK;
    logic               RST;
    logic               i_stb;
    logic signed [15:0] din [8];
    logic               o_stb_h, o_stb_v;
    logic signed [15:0] oh [8];
    logic signed [15:0] ov [8];

    idct_1d #(.horizontal(1'b1)) dut_h (
        .CLK(CLK), .RST(RST), .i_stb(i_stb),
        .i_D0(din[0]), .i_D1(din[1]), .i_D2(din[2]), .i_D3(din[3]),
        .i_D4(din[4]), .i_D5(din[5]), .i_D6(din[6]), .i_D7(din[7]),
        .o_stb(o_stb_h),
        .o_D0(oh[0]), .o_D1(oh[1]), .o_D2(oh[2]), .o_D3(oh[3]),
        .o_D4(oh[4]), .o_D5(oh[5]), .o_D6(oh[6]), .o_D7(oh[7])
    );

    idct_1d #(.horizontal(1'b0)) dut_v (
        .CLK(CLK), .RST(RST), .i_stb(i_stb),
        .i_D0(din[0]), .i_D1(din[1]), .i_D2(din[2]), .i_D3(din[3]),
        .i_D4(din[4]), .i_D5(din[5]), .i_D6(din[6]), .i_D7(din[7]),
        .o_stb(o_stb_v),
        .o_D0(ov[0]), .o_D1(ov[1]), .o_D2(ov[2]), .o_D3(ov[3]),
        .o_D4(ov[4]), .o_D5(ov[5]), .o_D6(ov[6]), .o_D7(ov[7])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [127:0] w_oh, w_ov;
    assign w_oh = {oh[7], oh[6], oh[5], oh[4], oh[3], oh[2], oh[1], oh[0]};
    assign w_ov = {ov[7], ov[6], ov[5], ov[4], ov[3], ov[2], ov[1], ov[0]};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: the stage equations evaluated as one plain 64-bit integer
    // computation per vector, then descaled.
    function automatic logic [127:0] ref_idct(input int d[8], input bit horiz);
        longint dd [8];
        longint e0, e1, m, tmp2, tmp3;
        longint z1, z2, z3, z4, z5, zz3, zz4;
        longint ev [4];
        longint b [4];
        longint r [8];
        longint y, rnd;
        int     s;
        logic [127:0] res;
        for (int i = 0; i < 8; i++) dd[i] = longint'(d[i]);
        e0   = (dd[0] + dd[4]) * 8192;
        e1   = (dd[0] - dd[4]) * 8192;
        m    = (dd[2] + dd[6]) * 4433;
        tmp2 = m - dd[6] * 15137;
        tmp3 = m + dd[2] * 6270;
        ev[0] = e0 + tmp3;
        ev[1] = e1 + tmp2;
        ev[2] = e1 - tmp2;
        ev[3] = e0 - tmp3;
        z1  = dd[7] + dd[1];
        z2  = dd[5] + dd[3];
        z3  = dd[7] + dd[3];
        z4  = dd[5] + dd[1];
        z5  = (z3 + z4) * 9633;
        zz3 = z5 - z3 * 16069;
        zz4 = z5 - z4 * 3196;
        b[0] = dd[7] * 2446  - z1 * 7373  + zz3;
        b[1] = dd[5] * 16819 - z2 * 20995 + zz4;
        b[2] = dd[3] * 25172 - z2 * 20995 + zz3;
        b[3] = dd[1] * 12299 - z1 * 7373  + zz4;
        for (int i = 0; i < 4; i++) begin
            r[i]     = ev[i] + b[3-i];
            r[7 - i] = ev[i] - b[3-i];
        end
        s   = horiz ? 11 : 18;
        rnd = longint'(1) << (s - 1);
        res = '0;
        for (int i = 0; i < 8; i++) begin
            y = (r[i] + rnd) >>> s;
            if (horiz) begin
                if (y > 32767)  y = 32767;
                if (y < -32768) y = -32768;
            end else begin
                y = y + 128;
                if (y > 255) y = 255;
                if (y < 0)   y = 0;
            end
            res[16*i +: 16] = 16'(y);
        end
        return res;
    endfunction

    function automatic logic [127:0] pack8(input int v[8]);
        logic [127:0] res;
        for (int i = 0; i < 8; i++) res[16*i +: 16] = 16'(v[i]);
        return res;
    endfunction

    // Record of what was captured at each edge (indexed mod 8) and the
    // output values the outputs should currently hold.
    int           cyc = 0;
    bit           hist_stb [8];
    int           hist_d [8][8];
    logic [127:0] exp_h = '0;
    logic [127:0] exp_v = '0;

    task automatic clear_expect();
        for (int i = 0; i < 8; i++) hist_stb[i] = 1'b0;
        exp_h = '0;
        exp_v = '0;
    endtask

    // Drive one vector (or an idle cycle) for one edge and check both DUTs
    // just after that edge.
    task automatic tick(input bit stb, input int d[8]);
        int slot, old;
        bit exp_stb;
        i_stb = stb;
        for (int i = 0; i < 8; i++) din[i] = 16'(d[i]);
        @(posedge CLK);
        #1;
        cyc++;
        slot = cyc % 8;
        old  = (cyc + 4) % 8;
        hist_stb[slot] = stb && !RST;
        hist_d[slot]   = d;
        exp_stb = hist_stb[old];
        if (exp_stb) begin
            exp_h = ref_idct(hist_d[old], 1'b1);
            exp_v = ref_idct(hist_d[old], 1'b0);
        end
        chk("stb_h", 128'(o_stb_h), 128'(exp_stb));
        chk("stb_v", 128'(o_stb_v), 128'(exp_stb));
        chk("dat_h", w_oh, exp_h);
        chk("dat_v", w_ov, exp_v);
    endtask

    task automatic idle(input int n);
        int z [8];
        for (int i = 0; i < 8; i++) z[i] = 0;
        for (int k = 0; k < n; k++) tick(1'b0, z);
    endtask

    task automatic dc(input int v);
        int d [8];
        for (int i = 0; i < 8; i++) d[i] = 0;
        d[0] = v;
        tick(1'b1, d);
    endtask

    task automatic rand_vec(input int lim, output int d[8]);
        for (int i = 0; i < 8; i++)
            d[i] = int'($urandom_range(0, 2 * lim)) - lim;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d [8];
        int v [8];
        RST   = 1'b1;
        i_stb = 1'b0;
        for (int i = 0; i < 8; i++) din[i] = '0;
        clear_expect();

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_stb_h", 128'(o_stb_h), 128'(0));
        chk("rst_stb_v", 128'(o_stb_v), 128'(0));
        chk("rst_dat_h", w_oh, 128'(0));
        chk("rst_dat_v", w_ov, 128'(0));
        RST = 1'b0;

        // Single DC vector.
        dc(64);
        idle(5);
        chk("dc64_h", w_oh, {8{16'd256}});
        chk("dc64_v", w_ov, {8{16'd130}});

        // Single first-harmonic vector.
        for (int i = 0; i < 8; i++) d[i] = 0;
        d[1] = 100;
        tick(1'b1, d);
        idle(5);
        v = '{555, 470, 314, 110, -110, -314, -470, -555};
        chk("ac1_h", w_oh, pack8(v));

        // Pass-2 level shift and clamps.
        dc(0);
        idle(4);
        chk("zero_v", w_ov, {8{16'd128}});
        dc(256);
        idle(4);
        chk("dc256_v", w_ov, {8{16'd136}});
        dc(8000);
        idle(4);
        chk("clamp_hi_v", w_ov, {8{16'd255}});
        dc(-8000);
        idle(4);
        chk("clamp_lo_v", w_ov, {8{16'd0}});

        // Streaming: 10 back-to-back, a 3-cycle gap, then 2 more.
        for (int k = 0; k < 10; k++) dc(37 * k - 150);
        idle(3);
        dc(500);
        dc(-500);
        idle(6);

        // Reset with three vectors in flight and one on the outputs.
        for (int k = 0; k < 4; k++) begin
            rand_vec(2047, d);
            tick(1'b1, d);
        end
        idle(1);
        chk("pre_rst_stb_h", 128'(o_stb_h), 128'(1));
        #2;
        RST = 1'b1;
        #1;
        chk("async_stb_h", 128'(o_stb_h), 128'(0));
        chk("async_stb_v", 128'(o_stb_v), 128'(0));
        chk("async_dat_h", w_oh, 128'(0));
        chk("async_dat_v", w_ov, 128'(0));
        clear_expect();
        rand_vec(2047, d);
        tick(1'b1, d);
        tick(1'b1, d);
        RST = 1'b0;
        rand_vec(2047, d);
        tick(1'b1, d);
        idle(6);

        // Random regression, with random gaps.
        for (int k = 0; k < 10000; k++) begin
            rand_vec((k < 5000) ? 2047 : 8191, d);
            tick($urandom_range(0, 3) != 0, d);
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
